shift_tx: RTL and testbench

- Parallel-in, serial-out transmitter. It is the transmit end of the serial link whose receive end is the team's serial-in shift register.
- Accepts an N-bit word through a valid/ready handshake.
- Emits the word MSB first on `sd`, with a one-cycle `sd_en` strobe per bit.
- MSB-first order means a receiver that shifts in at the LSB ends up with the word in original bit order.

---
 rtl/shift_tx_pkg.sv | 16 +
 rtl/shift_tx_bit_tick_gen.sv | 31 +++
 rtl/shift_tx.sv | 107 ++++++++++
 tb/tb_shift_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_tx_pkg.sv
// Shared types and helpers for the shift_tx serial transmitter.
package shift_tx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_t;

   // Counter width for a count range of x values; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned x);
      int unsigned w;
      w = $clog2(x);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/shift_tx_bit_tick_gen.sv
// Bit-period timer: pulses tick every DIV cycles while run is high.
module bit_tick_gen
   import shift_tx_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int unsigned   CW   = cnt_w(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   // Counter restarts from zero whenever run drops, so each frame starts aligned.
   always_ff @(posedge clk) begin
      if (reset || !run) begin
         div_cnt <= '0;
      end else if (div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   assign tick = run && (div_cnt == LAST);

endmodule

// File: rtl/shift_tx.sv
// Parallel-in, serial-out transmitter, MSB first with one sd_en strobe per bit.
// Define SHIFT_TX_PARITY_EN to append an even-parity bit to every frame.
module shift_tx
   import shift_tx_pkg::*;
#(
   parameter int unsigned N   = 8,
   parameter int unsigned DIV = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] load_data,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic         abort,
   output logic         sd,
   output logic         sd_en,
   output logic         busy,
   output logic         done
);

`ifdef SHIFT_TX_PARITY_EN
   localparam int unsigned F = N + 1;
`else
   localparam int unsigned F = N;
`endif
   localparam int unsigned   BW       = cnt_w(F + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(F - 1);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [F-1:0]  shift_reg;
   logic [F-1:0]  capture;
   logic [BW-1:0] bit_cnt;
   logic          run;
   logic          tick;
   logic          accept;

   // Parity rides at the bottom of the shift register so it leaves last.
`ifdef SHIFT_TX_PARITY_EN
   assign capture = {load_data, ^load_data};
`else
   assign capture = load_data;
`endif

   assign run = (state == SHIFT);

   bit_tick_gen #(
      .DIV (DIV)
   ) u_bit_tick_gen (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and strobes; abort and reset both suppress the current bit.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      accept     = 1'b0;
      sd         = 1'b0;
      sd_en      = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            load_ready = !reset;
            accept     = load_valid && !reset;
            if (accept) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy  = 1'b1;
            sd    = shift_reg[F-1];
            sd_en = tick && !abort && !reset;
            done  = sd_en && (bit_cnt == LAST_BIT);
            if (abort || done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (accept) begin
         shift_reg <= capture;
         bit_cnt   <= '0;
      end else if (sd_en) begin
         shift_reg <= {shift_reg[F-2:0], 1'b0};
         bit_cnt   <= bit_cnt + BW'(1);
      end
   end

endmodule

// File: tb/tb_shift_tx.sv
// Self-checking bench for shift_tx: DIV=1 instance with scoreboard, DIV=3 instance by hand.
module tb_shift_tx;

   localparam int unsigned N = 8;
`ifdef SHIFT_TX_PARITY_EN
   localparam int unsigned F = N + 1;
`else
   localparam int unsigned F = N;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [N-1:0] load_data1, load_data3;
   logic         load_valid1, load_valid3, abort1, abort3;
   logic         load_ready1, sd1, sd_en1, busy1, done1;
   logic         load_ready3, sd3, sd_en3, busy3, done3;

   shift_tx #(.N(N), .DIV(1)) dut1 (
      .clk(clk), .reset(reset), .load_data(load_data1), .load_valid(load_valid1),
      .load_ready(load_ready1), .abort(abort1), .sd(sd1), .sd_en(sd_en1),
      .busy(busy1), .done(done1)
   );

   shift_tx #(.N(N), .DIV(3)) dut3 (
      .clk(clk), .reset(reset), .load_data(load_data3), .load_valid(load_valid3),
      .load_ready(load_ready3), .abort(abort3), .sd(sd3), .sd_en(sd_en3),
      .busy(busy3), .done(done3)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected serial frame: data MSB first, then even parity when enabled.
   function automatic logic [F-1:0] frame_of(input logic [N-1:0] d);
`ifdef SHIFT_TX_PARITY_EN
      return {d, ^d};
`else
      return d;
`endif
   endfunction

   // Scoreboard for dut1: expected bits queued at the handshake, popped on sd_en.
   logic         exp_q[$];
   logic         exp_bit;
   logic [F-1:0] fr1;
   logic [F-1:0] rx      = '0;
   int           left    = 0;
   int           strobes = 0;

   always @(negedge clk) begin
      if (sd_en1) begin
         strobes++;
         rx = {rx[F-2:0], sd1};
         if (exp_q.size() == 0) begin
            check("sd_en_unexpected", 32'(sd_en1), 32'(0));
         end else begin
            exp_bit = exp_q.pop_front();
            check("sd_bit", 32'(sd1), 32'(exp_bit));
            left--;
         end
      end
      if (sd_en1 || done1)
         check("done_align", 32'(done1), 32'(sd_en1 && left == 0));
      if (load_valid1 && load_ready1) begin
         fr1 = frame_of(load_data1);
         for (int i = int'(F) - 1; i >= 0; i--) exp_q.push_back(fr1[i]);
         left    = int'(F);
         strobes = 0;
         rx      = '0;
      end else if ((abort1 || reset) && busy1) begin
         exp_q.delete();
         left = 0;
      end
   end

   typedef struct {
      logic [N-1:0] data;
      logic [F-1:0] exp_frame;
      int           exp_done_ofs;
   } vec_t;
   vec_t vecs[6];

   task automatic wait_ready1(input string name, output int k);
      bit seen = 1'b0;
      k = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         if (load_ready1) begin
            seen = 1'b1;
            k    = cyc;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!seen) check({name, "_ready_timeout"}, 32'(0), 32'(1));
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
   task automatic send1(input logic [N-1:0] d, output int k);
      load_data1  = d;
      load_valid1 = 1'b1;
      wait_ready1("send", k);
      @(posedge clk); #1;
      load_valid1 = 1'b0;
   endtask

   task automatic finish1(input string name, input int k, input logic [F-1:0] exp_frame,
                          input int exp_ofs);
      bit seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         if (done1) begin
            seen = 1'b1;
            check({name, "_done_latency"}, 32'(cyc - k), 32'(exp_ofs));
         end
      end
      if (!seen) check({name, "_done_timeout"}, 32'(0), 32'(1));
      #1;
      check({name, "_strobes"}, 32'(strobes), 32'(F));
      check({name, "_rx"}, 32'(rx), 32'(exp_frame));
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_ready_after"}, 32'(load_ready1), 32'(1));
      check({name, "_busy_after"}, 32'(busy1), 32'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   int           k, k2;
   logic [F-1:0] fr3;

   initial begin
      reset       = 1'b1;
      load_data1  = '0;
      load_data3  = '0;
      load_valid1 = 1'b0;
      load_valid3 = 1'b0;
      abort1      = 1'b0;
      abort3      = 1'b0;
      vecs[0] = '{8'hA5, frame_of(8'hA5), int'(F)};
      vecs[1] = '{8'h07, frame_of(8'h07), int'(F)};
      vecs[2] = '{8'h00, frame_of(8'h00), int'(F)};
      vecs[3] = '{8'hFF, frame_of(8'hFF), int'(F)};
      vecs[4] = '{8'h01, frame_of(8'h01), int'(F)};
      vecs[5] = '{8'h80, frame_of(8'h80), int'(F)};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_ready_low", 32'(load_ready1), 32'(0));
      check("rst_busy", 32'(busy1), 32'(0));
      check("rst_sd", 32'(sd1), 32'(0));
      check("rst_sd_en", 32'(sd_en1), 32'(0));
      check("rst_done", 32'(done1), 32'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready1", 32'(load_ready1), 32'(1));
      check("post_rst_ready3", 32'(load_ready3), 32'(1));
      check("post_rst_busy3", 32'(busy3), 32'(0));
      @(posedge clk); #1;

      // Table of single frames at DIV=1
      foreach (vecs[i]) begin
         send1(vecs[i].data, k);
         finish1($sformatf("vec%0d", i), k, vecs[i].exp_frame, vecs[i].exp_done_ofs);
      end

      // DIV=3: every bit held three cycles, strobe on the third
      load_data3  = 8'h81;
      load_valid3 = 1'b1;
      @(negedge clk);
      check("div3_ready", 32'(load_ready3), 32'(1));
      @(posedge clk); #1;
      load_valid3 = 1'b0;
      fr3 = frame_of(8'h81);
      for (int j = 1; j <= int'(F) * 3; j++) begin
         @(negedge clk);
         check($sformatf("div3_sd_en_c%0d", j), 32'(sd_en3), 32'(j % 3 == 0));
         check($sformatf("div3_sd_c%0d", j), 32'(sd3), 32'(fr3[int'(F) - 1 - (j - 1) / 3]));
         check($sformatf("div3_done_c%0d", j), 32'(done3), 32'(j == int'(F) * 3));
      end
      @(negedge clk);
      check("div3_ready_after", 32'(load_ready3), 32'(1));
      check("div3_sd_after", 32'(sd3), 32'(0));
      @(posedge clk); #1;

      // load_valid held high across two words
      load_data1  = 8'h0F;
      load_valid1 = 1'b1;
      wait_ready1("b2b_first", k);
      @(posedge clk); #1;
      load_data1 = 8'hF0;
      wait_ready1("b2b_second", k2);
      @(posedge clk); #1;
      load_valid1 = 1'b0;
      check("b2b_gap", 32'(k2 - k), 32'(F + 1));
      finish1("b2b", k2, frame_of(8'hF0), int'(F));

      // Abort on the 4th strobe
      send1(8'hFF, k);
      repeat (3) @(posedge clk);
      #1;
      abort1 = 1'b1;
      @(negedge clk);
      check("abort_no_strobe", 32'(sd_en1), 32'(0));
      check("abort_no_done", 32'(done1), 32'(0));
      check("abort_strobes_before", 32'(strobes), 32'(3));
      @(posedge clk); #1;
      abort1 = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy1), 32'(0));
      check("abort_ready", 32'(load_ready1), 32'(1));
      check("abort_sd", 32'(sd1), 32'(0));
      check("abort_sd_en", 32'(sd_en1), 32'(0));
      @(posedge clk); #1;

      // Abort coinciding with a load in IDLE: the load is accepted
      abort1 = 1'b1;
      send1(8'h5A, k);
      abort1 = 1'b0;
      finish1("idle_abort", k, frame_of(8'h5A), int'(F));

      // Reset after two bits, then a clean frame
      send1(8'h96, k);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_no_strobe", 32'(sd_en1), 32'(0));
      check("midrst_no_done", 32'(done1), 32'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy1), 32'(0));
      check("midrst_sd", 32'(sd1), 32'(0));
      check("midrst_sd_en", 32'(sd_en1), 32'(0));
      check("midrst_done", 32'(done1), 32'(0));
      check("midrst_ready", 32'(load_ready1), 32'(1));
      @(posedge clk); #1;
      send1(8'h3C, k);
      finish1("after_rst", k, frame_of(8'h3C), int'(F));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
